// File: rtl/pong_objects.sv
// Pong game-object stage: overlays the ball and paddles on the background and runs the per-frame game update.
// Optional `PONG_AI_EN makes the right paddle track the ball instead of following its buttons.
module pong_objects #(
  parameter int          H_ACTIVE      = 480,
  parameter int          V_ACTIVE      = 272,
  parameter int          BALL_SIZE     = 8,
  parameter int          PADDLE_W      = 8,
  parameter int          PADDLE_H      = 48,
  parameter int          PADDLE_MARGIN = 16,
  parameter int          BALL_STEP     = 2,
  parameter int          PADDLE_STEP   = 4,
  parameter int          SERVE_FRAMES  = 60,
  parameter logic [23:0] BALL_COLOR    = 24'hFFFFFF,
  parameter logic [23:0] PADDLE_COLOR  = 24'h00FF00
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [8:0]  i_x,
  input  logic [8:0]  i_y,
  input  logic [23:0] i_bg_rgb,
  input  logic        i_bg_valid,
  input  logic        i_l_up,
  input  logic        i_l_down,
  input  logic        i_r_up,
  input  logic        i_r_down,
  output logic [23:0] o_rgb,
  output logic        o_valid,
  output logic        o_frame,
  output logic [3:0]  o_score_l,
  output logic [3:0]  o_score_r,
  output logic        o_game_over
);

  localparam logic [8:0] BALL_X0 = 9'(H_ACTIVE/2 - BALL_SIZE/2);
  localparam logic [8:0] BALL_Y0 = 9'(V_ACTIVE/2 - BALL_SIZE/2);
  localparam logic [8:0] PAD_Y0  = 9'((V_ACTIVE - PADDLE_H)/2);
  localparam logic [9:0] PLX     = 10'(PADDLE_MARGIN);
  localparam logic [9:0] PRX     = 10'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W);
  localparam logic [9:0] PW      = 10'(PADDLE_W);
  localparam logic [9:0] PH      = 10'(PADDLE_H);
  localparam logic [9:0] BS      = 10'(BALL_SIZE);
  localparam logic [9:0] L_HIT   = 10'(PADDLE_MARGIN + PADDLE_W);
  localparam logic [9:0] R_HIT   = 10'(H_ACTIVE - PADDLE_MARGIN - PADDLE_W - BALL_SIZE);
  localparam logic [9:0] X_MAX   = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] Y_MAX   = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] P_MAX   = 10'(V_ACTIVE - PADDLE_H);
  localparam logic [9:0] B_STEP  = 10'(BALL_STEP);
  localparam logic [9:0] P_STEP  = 10'(PADDLE_STEP);
  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);

  typedef enum logic [4:0] {
    S_IDLE    = 5'b00001,
    S_PADDLES = 5'b00010,
    S_BALL_X  = 5'b00100,
    S_BALL_Y  = 5'b01000,
    S_SCORE   = 5'b10000
  } seq_t;

  typedef enum logic [1:0] {M_SERVE, M_PLAY, M_OVER} mode_t;

  seq_t       seq, seq_n;
  mode_t      mode, mode_n;
  logic [7:0] serve_cnt, serve_cnt_n;
  logic [8:0] bx, bx_n, by, by_n, ply, ply_n, pry, pry_n;
  logic       dx, dx_n, dy, dy_n;
  logic       miss_l, miss_l_n, miss_r, miss_r_n;
  logic [3:0] score_l_n, score_r_n;
  logic       corner, corner_d, frame_evt;
  logic       r_up, r_down;

  logic [9:0] bx10, by10, ply10, pry10, x10, y10;
  assign bx10  = {1'b0, bx};
  assign by10  = {1'b0, by};
  assign ply10 = {1'b0, ply};
  assign pry10 = {1'b0, pry};
  assign x10   = {1'b0, i_x};
  assign y10   = {1'b0, i_y};

  assign corner    = (i_x == 9'(H_ACTIVE - 1)) && (i_y == 9'(V_ACTIVE - 1));
  assign frame_evt = corner && !corner_d;

`ifdef PONG_AI_EN
  localparam logic [9:0] BS_HALF = 10'(BALL_SIZE/2);
  localparam logic [9:0] PH_HALF = 10'(PADDLE_H/2);
  assign r_up   = (by10 + BS_HALF) < (pry10 + PH_HALF);
  assign r_down = (by10 + BS_HALF) > (pry10 + PH_HALF);
`else
  assign r_up   = i_r_up;
  assign r_down = i_r_down;
`endif

  function automatic logic [8:0] paddle_next(input logic [8:0] y, input logic up, input logic down);
    logic [9:0] y10;
    y10 = {1'b0, y};
    paddle_next = y;
    if (up && !down)
      paddle_next = (y10 < P_STEP) ? '0 : 9'(y10 - P_STEP);
    else if (down && !up)
      paddle_next = (y10 + P_STEP > P_MAX) ? P_MAX[8:0] : 9'(y10 + P_STEP);
  endfunction

  logic l_overlap, r_overlap;
  assign l_overlap = (by10 + BS > ply10) && (by10 < ply10 + PH);
  assign r_overlap = (by10 + BS > pry10) && (by10 < pry10 + PH);

  always_comb begin
    seq_n       = seq;
    mode_n      = mode;
    serve_cnt_n = serve_cnt;
    bx_n        = bx;
    by_n        = by;
    dx_n        = dx;
    dy_n        = dy;
    ply_n       = ply;
    pry_n       = pry;
    miss_l_n    = miss_l;
    miss_r_n    = miss_r;
    score_l_n   = o_score_l;
    score_r_n   = o_score_r;
    case (seq)
      S_IDLE: if (frame_evt) seq_n = S_PADDLES;
      S_PADDLES: begin
        seq_n = S_BALL_X;
        if (mode != M_OVER) begin
          ply_n = paddle_next(ply, i_l_up, i_l_down);
          pry_n = paddle_next(pry, r_up, r_down);
        end
      end
      S_BALL_X: begin
        seq_n = S_BALL_Y;
        if (mode == M_PLAY) begin
          if (!dx) begin
            if (bx10 <= L_HIT && l_overlap) begin
              bx_n = L_HIT[8:0];
              dx_n = 1'b1;
            end else if (bx10 < B_STEP) miss_l_n = 1'b1;
            else bx_n = 9'(bx10 - B_STEP);
          end else begin
            if (bx10 >= R_HIT && r_overlap) begin
              bx_n = R_HIT[8:0];
              dx_n = 1'b0;
            end else if (bx10 + B_STEP > X_MAX) miss_r_n = 1'b1;
            else bx_n = 9'(bx10 + B_STEP);
          end
        end
      end
      S_BALL_Y: begin
        seq_n = S_SCORE;
        if (mode == M_PLAY) begin
          if (!dy) begin
            if (by10 < B_STEP) begin
              by_n = '0;
              dy_n = 1'b1;
            end else by_n = 9'(by10 - B_STEP);
          end else begin
            if (by10 + B_STEP > Y_MAX) begin
              by_n = Y_MAX[8:0];
              dy_n = 1'b0;
            end else by_n = 9'(by10 + B_STEP);
          end
        end
      end
      S_SCORE: begin
        seq_n = S_IDLE;
        if (mode == M_SERVE) begin
          if (serve_cnt == SERVE_LAST) begin
            serve_cnt_n = '0;
            mode_n      = M_PLAY;
          end else serve_cnt_n = serve_cnt + 8'd1;
        end else if (mode == M_PLAY && (miss_l || miss_r)) begin
          miss_l_n = 1'b0;
          miss_r_n = 1'b0;
          bx_n     = BALL_X0;
          by_n     = BALL_Y0;
          mode_n   = M_SERVE;
          // The serve heads toward the player who just conceded.
          if (miss_l) begin
            score_r_n = o_score_r + 4'd1;
            dx_n      = 1'b0;
            if (o_score_r == 4'd8) mode_n = M_OVER;
          end else begin
            score_l_n = o_score_l + 4'd1;
            dx_n      = 1'b1;
            if (o_score_l == 4'd8) mode_n = M_OVER;
          end
        end
      end
      default: seq_n = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      seq       <= S_IDLE;
      mode      <= M_SERVE;
      serve_cnt <= '0;
      bx        <= BALL_X0;
      by        <= BALL_Y0;
      dx        <= 1'b1;
      dy        <= 1'b1;
      ply       <= PAD_Y0;
      pry       <= PAD_Y0;
      miss_l    <= 1'b0;
      miss_r    <= 1'b0;
      o_score_l <= '0;
      o_score_r <= '0;
      corner_d  <= 1'b0;
      o_frame   <= 1'b0;
    end else begin
      seq       <= seq_n;
      mode      <= mode_n;
      serve_cnt <= serve_cnt_n;
      bx        <= bx_n;
      by        <= by_n;
      dx        <= dx_n;
      dy        <= dy_n;
      ply       <= ply_n;
      pry       <= pry_n;
      miss_l    <= miss_l_n;
      miss_r    <= miss_r_n;
      o_score_l <= score_l_n;
      o_score_r <= score_r_n;
      corner_d  <= corner;
      o_frame   <= frame_evt;
    end
  end

  assign o_game_over = (mode == M_OVER);

  logic in_ball, in_pad;
  assign in_ball = (mode != M_OVER) &&
                   (x10 >= bx10) && (x10 < bx10 + BS) && (y10 >= by10) && (y10 < by10 + BS);
  assign in_pad  = ((x10 >= PLX) && (x10 < PLX + PW) && (y10 >= ply10) && (y10 < ply10 + PH)) ||
                   ((x10 >= PRX) && (x10 < PRX + PW) && (y10 >= pry10) && (y10 < pry10 + PH));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_rgb   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_rgb   <= in_ball ? BALL_COLOR : (in_pad ? PADDLE_COLOR : i_bg_rgb);
      o_valid <= i_bg_valid;
    end
  end

endmodule
